// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam int          BE_W      = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {OWN_IF, OWN_D} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oor;
  } resp_tag_t;

  // Word index past the end of the attached BRAM.
  function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
    return {2'b00, addr[31:2]} >= depth;
  endfunction

  // Starvation counter width; at least one bit even when the override is off.
  function automatic int starve_cw(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bram_arb_prio.sv
// Grant selection: data has priority, fetch is forced through after a run of denials.
module bram_arb_prio
  import bram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int            CW  = starve_cw(STARVE_LIMIT);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          force_if;

  assign force_if = (STARVE_LIMIT != 0) && (starve_cnt == LIM);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset_n) begin
      if (if_req && (!d_req || force_if)) if_gnt = 1'b1;
      else if (d_req)                      d_gnt  = 1'b1;
    end
  end

  // Counts consecutive denied fetch cycles; any grant or idle fetch clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between instruction fetch and the load/store unit.
module bram_port_arbiter
  import bram_arb_pkg::BE_W, bram_arb_pkg::OWN_IF, bram_arb_pkg::OWN_D,
         bram_arb_pkg::resp_tag_t, bram_arb_pkg::addr_oor;
#(
  parameter int          MEM_DEPTH    = 1096,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_INSTR    = bram_arb_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [31:0]     if_rdata,
  input  logic            d_req,
  input  logic [31:0]     d_addr,
  input  logic [BE_W-1:0] d_we,
  input  logic [31:0]     d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [31:0]     d_rdata,
  output logic            d_err,
  output logic            mem_en,
  output logic [BE_W-1:0] mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  logic      oor_if, oor_d;
  resp_tag_t tag_d, tag_q;

  bram_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk     (clk),
    .reset_n (reset_n),
    .if_req  (if_req),
    .d_req   (d_req),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt)
  );

  assign oor_if = addr_oor(if_addr, 32'(MEM_DEPTH));
  assign oor_d  = addr_oor(d_addr,  32'(MEM_DEPTH));

  // Out-of-range accesses are granted and tagged, but never reach the BRAM.
  always_comb begin
    tag_d     = '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = d_addr;
    mem_wdata = d_wdata;
    if (if_gnt) begin
      tag_d    = '{valid: 1'b1, owner: OWN_IF, oor: oor_if};
      mem_en   = !oor_if;
      mem_addr = if_addr;
    end else if (d_gnt) begin
      tag_d    = '{valid: 1'b1, owner: OWN_D, oor: oor_d};
      mem_en   = !oor_d;
      mem_we   = oor_d ? '0 : d_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tag_q <= '0;
    else          tag_q <= tag_d;
  end

  assign if_rvalid = tag_q.valid && (tag_q.owner == OWN_IF);
  assign d_rvalid  = tag_q.valid && (tag_q.owner == OWN_D);
  assign d_err     = d_rvalid && tag_q.oor;
  assign if_rdata  = tag_q.oor ? NOP_INSTR : mem_rdata;
  assign d_rdata   = tag_q.oor ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (starvation limit 4 and 0) on shared stimulus.
module tb_bram_port_arbiter;

  localparam int DEPTH = 1096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_we;

  logic [1:0]       if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_we;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h1122_3344 : 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    return w;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  genvar gk;
  generate
    for (gk = 0; gk < 2; gk++) begin : g_dut
      logic [31:0] ram [DEPTH];
      logic [31:0] rd;

      bram_port_arbiter #(
        .MEM_DEPTH   (DEPTH),
        .STARVE_LIMIT((gk == 0) ? 4 : 0),
        .NOP_INSTR   (32'h0000_0013)
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt[gk]),
        .if_rvalid (if_rvalid[gk]),
        .if_rdata  (if_rdata[gk]),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt[gk]),
        .d_rvalid  (d_rvalid[gk]),
        .d_rdata   (d_rdata[gk]),
        .d_err     (d_err[gk]),
        .mem_en    (mem_en[gk]),
        .mem_we    (mem_we[gk]),
        .mem_addr  (mem_addr[gk]),
        .mem_wdata (mem_wdata[gk]),
        .mem_rdata (mem_rdata[gk])
      );

      initial for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);

      // Write-first BRAM: registered output carries the merged word.
      always @(posedge clk) begin
        if (mem_en[gk] && !is_oor(mem_addr[gk])) begin
          ram[widx(mem_addr[gk])] <= merge(ram[widx(mem_addr[gk])], mem_we[gk], mem_wdata[gk]);
          rd <= merge(ram[widx(mem_addr[gk])], mem_we[gk], mem_wdata[gk]);
        end
      end
      assign mem_rdata[gk] = rd;
    end
  endgenerate

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: per instance, a denial run length, expected memory and the pending response.
  int          starve [2];
  logic [31:0] mm [2][DEPTH];
  bit          pv [2], pown_d [2], poor [2];
  logic [31:0] pdat [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      starve[k] = 0;
      pv[k]     = 1'b0;
      for (int i = 0; i < DEPTH; i++) mm[k][i] = init_word(i);
    end
  end

  always @(negedge clk) begin : p_cmp
    int          lim;
    bit          eif, ed, o;
    logic [31:0] wa;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 4 : 0;
      if (!reset_n) begin
        chk("rst_if_gnt",    k, 32'(if_gnt[k]),    0);
        chk("rst_d_gnt",     k, 32'(d_gnt[k]),     0);
        chk("rst_if_rvalid", k, 32'(if_rvalid[k]), 0);
        chk("rst_d_rvalid",  k, 32'(d_rvalid[k]),  0);
        chk("rst_d_err",     k, 32'(d_err[k]),     0);
        chk("rst_mem_en",    k, 32'(mem_en[k]),    0);
        chk("rst_mem_we",    k, 32'(mem_we[k]),    0);
        pv[k]     = 1'b0;
        starve[k] = 0;
      end else begin
        chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(pv[k] && !pown_d[k]));
        chk("d_rvalid",  k, 32'(d_rvalid[k]),  32'(pv[k] && pown_d[k]));
        if (pv[k] && !pown_d[k]) chk("if_rdata", k, if_rdata[k], pdat[k]);
        if (pv[k] && pown_d[k]) begin
          chk("d_rdata", k, d_rdata[k], pdat[k]);
          chk("d_err",   k, 32'(d_err[k]), 32'(poor[k]));
        end else begin
          chk("d_err", k, 32'(d_err[k]), 0);
        end
        eif = if_req && (!d_req || (lim != 0 && starve[k] >= lim));
        ed  = d_req && !eif;
        wa  = eif ? if_addr : d_addr;
        o   = is_oor(wa);
        chk("if_gnt",    k, 32'(if_gnt[k]), 32'(eif));
        chk("d_gnt",     k, 32'(d_gnt[k]),  32'(ed));
        chk("mem_en",    k, 32'(mem_en[k]), 32'((eif || ed) && !o));
        chk("mem_we",    k, 32'(mem_we[k]), (ed && !o) ? 32'(d_we) : 0);
        chk("mem_wdata", k, mem_wdata[k], d_wdata);
        if ((eif || ed) && !o) chk("mem_addr", k, mem_addr[k], wa);
        pv[k]     = eif || ed;
        pown_d[k] = ed;
        poor[k]   = o;
        if (o) begin
          pdat[k] = eif ? 32'h0000_0013 : 32'h0;
        end else if (eif || ed) begin
          pdat[k] = ed ? merge(mm[k][widx(wa)], d_we, d_wdata) : mm[k][widx(wa)];
          mm[k][widx(wa)] = pdat[k];
        end
        if (if_req && !eif) starve[k] = (starve[k] < lim) ? starve[k] + 1 : starve[k];
        else                starve[k] = 0;
      end
    end
  end

  logic [1:0] s_if_gnt, s_d_gnt, s_mem_en;

  // Present one request set for a cycle; returns 1ns after the accept edge.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                      input logic [3:0] we, input logic [31:0] wd);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
    @(negedge clk);
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_mem_en = mem_en;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int cif [2];
    int cd  [2];
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_addr = 32'h0; d_we = 4'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_if_gnt",  0, 32'(if_gnt[0]),   0);
    chk("lit_rst_d_gnt",   0, 32'(d_gnt[0]),    0);
    chk("lit_rst_mem_en",  0, 32'(mem_en[0]),   0);
    chk("lit_rst_rvalid",  0, 32'(if_rvalid[0] | d_rvalid[0]), 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 4'h0, 0);

    // Fetch stream
    step(1, 32'h0, 0, 0, 4'h0, 0);
    chk("lit_f0_rvalid", 0, 32'(if_rvalid[0]), 1);
    chk("lit_f0_rdata",  0, if_rdata[0], 32'hC0DE_0000);
    step(1, 32'h4, 0, 0, 4'h0, 0);
    chk("lit_f1_rdata",  0, if_rdata[0], 32'hC0DE_0001);
    step(1, 32'h8, 0, 0, 4'h0, 0);
    chk("lit_f2_rdata",  0, if_rdata[0], 32'hC0DE_0002);

    // Byte-masked write then read back
    step(0, 0, 1, 32'h10, 4'b0011, 32'hAABB_CCDD);
    chk("lit_wr_rvalid", 0, 32'(d_rvalid[0]), 1);
    chk("lit_wr_rdata",  0, d_rdata[0], 32'h1122_CCDD);
    step(0, 0, 1, 32'h10, 4'h0, 0);
    chk("lit_rd_rdata",  1, d_rdata[1], 32'h1122_CCDD);
    step(0, 0, 0, 0, 4'h0, 0);

    // Sustained contention
    for (int k = 0; k < 2; k++) begin cif[k] = 0; cd[k] = 0; end
    for (int c = 0; c < 20; c++) begin
      step(1, 32'h20, 1, 32'h24, 4'h0, 0);
      for (int k = 0; k < 2; k++) begin
        cif[k] += int'(s_if_gnt[k]);
        cd[k]  += int'(s_d_gnt[k]);
      end
    end
    chk("lit_cont_if_gnts",  0, 32'(cif[0]), 4);
    chk("lit_cont_d_gnts",   0, 32'(cd[0]),  16);
    chk("lit_nolim_if_gnts", 1, 32'(cif[1]), 0);
    chk("lit_nolim_d_gnts",  1, 32'(cd[1]),  20);
    step(0, 0, 0, 0, 4'h0, 0);

    // Range boundary
    step(1, 32'h1120, 0, 0, 4'h0, 0);
    chk("lit_oor_mem_en", 0, 32'(s_mem_en[0]), 0);
    chk("lit_oor_if_rdata", 0, if_rdata[0], 32'h0000_0013);
    step(1, 32'h111C, 0, 0, 4'h0, 0);
    chk("lit_last_mem_en", 0, 32'(s_mem_en[0]), 1);
    chk("lit_last_rdata",  0, if_rdata[0], 32'hC0DE_0447);
    step(0, 0, 1, 32'h2000, 4'h0, 0);
    chk("lit_oor_d_err",   0, 32'(d_err[0]), 1);
    chk("lit_oor_d_rdata", 0, d_rdata[0], 32'h0);
    step(0, 0, 1, 32'h2000, 4'hF, 32'h1234_5678);
    chk("lit_oor_wr_en",   0, 32'(s_mem_en[0]), 0);

    // Write then fetch of the same word, ordered by grant
    step(0, 0, 1, 32'h30, 4'hF, 32'hDEAD_BEEF);
    step(1, 32'h30, 0, 0, 4'h0, 0);
    chk("lit_raw_if_rdata", 0, if_rdata[0], 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 4'h0, 0);

    // Reset between grant and response
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h10; d_we = 4'h0;
    @(negedge clk);
    #2;
    chk("lit_pre_rst_d_gnt", 0, 32'(d_gnt[0]), 1);
    reset_n = 1'b0;
    #1;
    chk("lit_in_rst_d_gnt",  0, 32'(d_gnt[0]),  0);
    chk("lit_in_rst_mem_en", 0, 32'(mem_en[0]), 0);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    @(posedge clk);
    #1;
    chk("lit_rst_drop_rvalid", 0, 32'(d_rvalid[0]), 0);
    chk("lit_rst_if_gnt_held", 0, 32'(if_gnt[0]),   0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("lit_rel_if_gnt",   0, 32'(if_gnt[0]),   1);
    chk("lit_rel_d_rvalid", 0, 32'(d_rvalid[0]), 0);
    @(posedge clk);
    #1;
    chk("lit_rel_if_rvalid", 0, 32'(if_rvalid[0]), 1);
    chk("lit_rel_if_rdata",  0, if_rdata[0], 32'hC0DE_0002);
    step(0, 0, 0, 0, 4'h0, 0);
    step(0, 0, 0, 0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single read/write port of the 32-bit word BRAM between two requesters: instruction fetch (read-only) and the load/store unit (read or byte-masked write).
- Sits between the core and the BRAM. Drives the BRAM enable, address, write-data and write-enable signals. Routes the 1-cycle registered read data back to the requester that owned the access.
- Data port has priority. A starvation limit guarantees forward progress for fetch.

Parameters:
- MEM_DEPTH, 1096, number of 32-bit words in the attached BRAM; used for the range check.
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch is forced a grant; 0 disables the override (pure data priority).
- NOP_INSTR, 32'h00000013, data returned to fetch for out-of-range addresses.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address; bits [1:0] are ignored
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch response data
- d_req  in  1  data request
- d_addr  in  32  data byte address; bits [1:0] are ignored
- d_we  in  4  byte write enables; 0 = read
- d_wdata  in  32  write data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (read data, or write acknowledge)
- d_rdata  out  32  read data, or merged post-write word
- d_err  out  1  qualifies d_rvalid: address was out of range
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  32  BRAM byte address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM registered output, valid 1 cycle after mem_en

Behaviour:
- Handshake
  - A request is accepted in cycle N when req && gnt are both high.
  - The requester holds its signals stable until it sees gnt.
  - At most one request is accepted per cycle; the block is fully pipelined and can accept back-to-back every cycle.
- Arbitration (combinational from the current req lines and the starvation counter)
  - Only one requester asks: that requester wins.
  - Both ask: data wins, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0, in which case fetch wins.
- Starvation counter
  - Increments, saturating, each cycle if_req is high and if_gnt is low.
  - Clears on if_gnt, and clears when if_req is low.
- Range check
  - Out of range means addr[31:2] >= MEM_DEPTH.
  - An out-of-range access is still granted, but mem_en and mem_we are held at 0 that cycle.
- Memory drive
  - In-range accepted access: mem_en=1, mem_addr = winner's address.
  - mem_we = d_we for a data access, 0 for a fetch.
  - mem_wdata = d_wdata.
  - No access: mem_en=0, mem_we=0.
  - mem_addr and mem_wdata follow the data port when idle; they are don't-care.
- Response tag
  - Registered on the accept edge: {valid, owner, oor}.
  - In cycle N+1 exactly one of if_rvalid or d_rvalid pulses, for exactly 1 cycle.
- Response data
  - if_rdata = oor ? NOP_INSTR : mem_rdata.
  - d_rdata = oor ? 0 : mem_rdata.
  - d_err = oor, for a data response only.
  - A write acknowledge returns the merged word supplied by the BRAM.
  - if_rdata and d_rdata are don't-care when their rvalid is low.
  - rdata is not stored beyond N+1; requesters must capture on rvalid.
- Latency: 1 cycle from accept to response, for both ports and for out-of-range accesses.
- Reset (reset_n low, asynchronous)
  - Tag valid=0 and starve_cnt=0.
  - if_rvalid, d_rvalid, d_err, mem_en and mem_we are forced 0 while reset is asserted.
  - An in-flight response is dropped; no rvalid appears after reset is released.
  - gnt outputs are forced 0 while reset_n is low.
- Simultaneous events
  - Reset release in the same cycle as req: reset_n is sampled high at the edge, so the first grant is possible in the first cycle after release.
  - A data write to the address fetch reads next cycle is ordered by grant order; no forwarding is done.

Decomposition:
- Package bram_arb_pkg:
  - NOP_INSTR constant
  - owner_e enum {OWN_IF, OWN_D}
  - resp_tag_t struct {valid, owner_e owner, oor}
  - BE_W = 4
- One sub-module: bram_arb_prio. It contains the starvation counter and the grant logic: inputs if_req, d_req; outputs if_gnt, d_gnt. The top-level module contains the range check, memory drive, tag register and response routing.

Test Plan:
- Fetch only: if_req with if_addr 0x0,0x4,0x8 on consecutive cycles → if_gnt=1 each cycle; if_rvalid in cycles N+1..N+3 carrying BRAM words 0..2; mem_we=0 throughout.
- Data write, then read: d_req, d_addr=0x10, d_we=4'b0011, d_wdata=0xAABBCCDD over an old word of 0x11223344 → next cycle d_rvalid=1, d_rdata=0x1122CCDD; a read of 0x10 then returns 0x1122CCDD.
- Contention with STARVE_LIMIT=4: if_req and d_req held high continuously → d_gnt for 4 cycles, if_gnt in the 5th cycle, then the pattern repeats; no cycle has both gnts set.
- Out of range with MEM_DEPTH=1096: if_addr=0x1120 → mem_en=0, next cycle if_rvalid=1, if_rdata=0x00000013. Data read at 0x2000 → d_rvalid=1, d_err=1, d_rdata=0.
- Reset mid-operation: accept a data read, then assert reset_n=0 before the next edge → d_rvalid stays 0 and all outputs are 0. After release, a new fetch request is granted on the first cycle.
- STARVE_LIMIT=0 with both requesting for 20 cycles → d_gnt every cycle, if_gnt never.
